axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter_pkg.sv | 12 +
 rtl/axis_rr_arbiter_if.sv | 25 ++
 rtl/axis_rr_arbiter_rr_pick.sv | 33 +++
 rtl/axis_rr_arbiter.sv | 80 ++++++++
 tb/tb_axis_rr_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types for the AXI-Stream output-stage arbiters.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int PACKET_MODE_BEAT   = 0;
  localparam int PACKET_MODE_PACKET = 1;

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Request/handshake observation bus and mux select outputs of the stream arbiter.
interface axis_rr_arbiter_if #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
);

  logic [CHANNEL_NUMBER-1:0]       req_valid;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic                            en;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl;
  logic                            busy;

  modport master (
    output req_valid, out_valid, out_ready, out_last,
    input  en, ctrl, busy
  );

  modport slave (
    input  req_valid, out_valid, out_ready, out_last,
    output en, ctrl, busy
  );

endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping modulo CHANNEL_NUMBER.
// Latency: purely combinational.
// Backpressure: none; reports whatever is requested this cycle.
module rr_pick #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic [CHANNEL_NUMBER-1:0]       req,
  input  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr,
  output logic                            any,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] winner
);

  localparam logic [CHANNEL_NUMBER_WIDTH:0] CH_COUNT = CHANNEL_NUMBER[CHANNEL_NUMBER_WIDTH:0];

  logic [CHANNEL_NUMBER-1:0]       rot;
  logic [CHANNEL_NUMBER_WIDTH-1:0] off;
  logic [CHANNEL_NUMBER_WIDTH:0]   sum;

  always_comb begin
    any    = |req;
    // rot[k] is channel (ptr + k) mod N; ptr < N always, so the doubled copy covers the wrap
    rot    = CHANNEL_NUMBER'({req, req} >> ptr);
    off    = '0;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
      if (rot[k]) off = CHANNEL_NUMBER_WIDTH'(k);
    end
    sum    = {1'b0, ptr} + {1'b0, off};
    if (sum >= CH_COUNT) sum = sum - CH_COUNT;
    winner = sum[CHANNEL_NUMBER_WIDTH-1:0];
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin select generator (en/ctrl) for the N:1 stream mux.
// Latency: grant visible one cycle after a request; back-to-back re-grant with no bubble.
// Backpressure: grant held through stalls until the releasing handshake (TLAST beat or any beat).
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int PACKET_MODE          = PACKET_MODE_PACKET
) (
  input logic              clk,
  input logic              rst,
  axis_rr_arbiter_if.slave bus
);

  arb_state_t                      state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_q, ptr_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] winner;
  logic [CHANNEL_NUMBER_WIDTH-1:0] next_ptr;
  logic                            any;
  logic                            hs;
  logic                            rel;
  logic                            grant;

  rr_pick #(
    .CHANNEL_NUMBER       (CHANNEL_NUMBER),
    .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner)
  );

  assign hs       = bus.out_valid & bus.out_ready;
  assign rel      = (PACKET_MODE == PACKET_MODE_PACKET) ? (hs & bus.out_last) : hs;
  assign next_ptr = (winner == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1))
                    ? '0 : winner + CHANNEL_NUMBER_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ctrl_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    ptr_d   = ptr_q;
    grant   = 1'b0;
    case (state_q)
      ARB_IDLE:   grant = any;
      ARB_LOCKED: begin
        // en stays high through the releasing beat; re-grant in the same cycle avoids a bubble
        if (rel) begin
          if (any) grant = 1'b1;
          else     state_d = ARB_IDLE;
        end
      end
      default:    state_d = ARB_IDLE;
    endcase
    if (grant) begin
      state_d = ARB_LOCKED;
      ctrl_d  = winner;
      ptr_d   = next_ptr;
    end
  end

  assign bus.en   = (state_q == ARB_LOCKED);
  assign bus.busy = (state_q == ARB_LOCKED);
  assign bus.ctrl = ctrl_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: packet-mode and beat-mode instances share one stimulus stream.
module tb_axis_rr_arbiter;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         ov, ordy, olast;

  int tests = 0;
  int fails = 0;

  // reference state per instance: index 0 = packet mode, 1 = beat mode
  int m_locked [2];
  int m_ctrl   [2];
  int m_ptr    [2];

  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.CHANNEL_NUMBER(N)) bus0 ();
  axis_rr_arbiter_if #(.CHANNEL_NUMBER(N)) bus1 ();

  assign bus0.req_valid = req;
  assign bus0.out_valid = ov;
  assign bus0.out_ready = ordy;
  assign bus0.out_last  = olast;
  assign bus1.req_valid = req;
  assign bus1.out_valid = ov;
  assign bus1.out_ready = ordy;
  assign bus1.out_last  = olast;

  axis_rr_arbiter #(.CHANNEL_NUMBER(N), .PACKET_MODE(1)) dut_pkt (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  axis_rr_arbiter #(.CHANNEL_NUMBER(N), .PACKET_MODE(0)) dut_beat (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int m);
    int w;
    bit rel;
    if (rst) begin
      m_locked[m] = 0;
      m_ctrl[m]   = 0;
      m_ptr[m]    = 0;
      return;
    end
    w   = pick(req, m_ptr[m]);
    rel = (m == 0) ? (ov && ordy && olast) : (ov && ordy);
    if (m_locked[m] == 0 || rel) begin
      if (w >= 0) begin
        m_locked[m] = 1;
        m_ctrl[m]   = w;
        m_ptr[m]    = (w + 1) % N;
      end else begin
        m_locked[m] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ov = 1'b0; ordy = 1'b0; olast = 1'b0;
    step();
    tests++; if (bus0.en !== 1'b0)    begin fails++; $display("FAIL reset_en_pkt got=%b want=0", bus0.en); end
    tests++; if (bus0.ctrl !== 3'd0)  begin fails++; $display("FAIL reset_ctrl_pkt got=%0d want=0", bus0.ctrl); end
    tests++; if (bus0.busy !== 1'b0)  begin fails++; $display("FAIL reset_busy_pkt got=%b want=0", bus0.busy); end
    tests++; if (bus1.en !== 1'b0)    begin fails++; $display("FAIL reset_en_beat got=%b want=0", bus1.en); end
    tests++; if (bus1.ctrl !== 3'd0)  begin fails++; $display("FAIL reset_ctrl_beat got=%0d want=0", bus1.ctrl); end
    rst = 1'b0;
    step();
    tests++; if (bus0.en !== 1'b0)    begin fails++; $display("FAIL idle_no_req_en got=%b want=0", bus0.en); end
  endtask

  task automatic test_single_req();
    req = 5'b00100;
    step();
    tests++; if (bus0.en !== 1'b1)    begin fails++; $display("FAIL single_en got=%b want=1", bus0.en); end
    tests++; if (bus0.ctrl !== 3'd2)  begin fails++; $display("FAIL single_ctrl got=%0d want=2", bus0.ctrl); end
    tests++; if (bus0.busy !== 1'b1)  begin fails++; $display("FAIL single_busy got=%b want=1", bus0.busy); end
    // pointer should now sit at 3: releasing with everyone requesting must pick 3
    req = 5'b11111; ov = 1'b1; ordy = 1'b1; olast = 1'b1;
    step();
    tests++; if (bus0.ctrl !== 3'd3)  begin fails++; $display("FAIL single_ptr_next got=%0d want=3", bus0.ctrl); end
  endtask

  task automatic test_back_to_back();
    int exp_seq [7] = '{0, 1, 2, 3, 4, 0, 1};
    rst = 1'b1; step(); rst = 1'b0;
    req = 5'b11111; ov = 1'b1; ordy = 1'b1; olast = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'(exp_seq[i]))
        begin fails++; $display("FAIL b2b_pkt[%0d] got en=%b ctrl=%0d want en=1 ctrl=%0d", i, bus0.en, bus0.ctrl, exp_seq[i]); end
      tests++; if (bus1.en !== 1'b1 || bus1.ctrl !== 3'(exp_seq[i]))
        begin fails++; $display("FAIL b2b_beat[%0d] got en=%b ctrl=%0d want en=1 ctrl=%0d", i, bus1.en, bus1.ctrl, exp_seq[i]); end
    end
  endtask

  task automatic test_packet_stall();
    logic [N-1:0] req_t  [4] = '{5'b00010, 5'b01010, 5'b01010, 5'b01010};
    logic         rdy_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic         last_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int           exp_t  [4] = '{1, 1, 1, 3};
    rst = 1'b1; step(); rst = 1'b0;
    req = 5'b00010; ov = 1'b0; ordy = 1'b0; olast = 1'b0;
    step();
    tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'd1)
      begin fails++; $display("FAIL stall_grant got en=%b ctrl=%0d want en=1 ctrl=1", bus0.en, bus0.ctrl); end
    for (int i = 0; i < 4; i++) begin
      req = req_t[i]; ov = 1'b1; ordy = rdy_t[i]; olast = last_t[i];
      step();
      tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'(exp_t[i]))
        begin fails++; $display("FAIL stall_beat[%0d] got en=%b ctrl=%0d want en=1 ctrl=%0d", i, bus0.en, bus0.ctrl, exp_t[i]); end
    end
  endtask

  task automatic test_hold_last();
    // continues from channel 3 locked, pointer at 4
    req = 5'b11111; ov = 1'b1; ordy = 1'b0; olast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'd3)
        begin fails++; $display("FAIL hold_last[%0d] got en=%b ctrl=%0d want en=1 ctrl=3", i, bus0.en, bus0.ctrl); end
    end
    ordy = 1'b1;
    step();
    tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'd4)
      begin fails++; $display("FAIL hold_release got en=%b ctrl=%0d want en=1 ctrl=4", bus0.en, bus0.ctrl); end
    req = '0; ov = 1'b1; ordy = 1'b1; olast = 1'b1;
    step();
    tests++; if (bus0.en !== 1'b0 || bus0.ctrl !== 3'd4)
      begin fails++; $display("FAIL release_to_idle got en=%b ctrl=%0d want en=0 ctrl=4", bus0.en, bus0.ctrl); end
  endtask

  task automatic test_beat_rr();
    int exp_seq [4] = '{0, 2, 0, 2};
    rst = 1'b1; step(); rst = 1'b0;
    req = 5'b00101; ov = 1'b1; ordy = 1'b1; olast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (bus1.en !== 1'b1 || bus1.ctrl !== 3'(exp_seq[i]))
        begin fails++; $display("FAIL beat_rr[%0d] got en=%b ctrl=%0d want en=1 ctrl=%0d", i, bus1.en, bus1.ctrl, exp_seq[i]); end
      tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'd0)
        begin fails++; $display("FAIL beat_rr_pkt_hold[%0d] got en=%b ctrl=%0d want en=1 ctrl=0", i, bus0.en, bus0.ctrl); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    req = 5'b10000; ov = 1'b0; ordy = 1'b0; olast = 1'b0;
    step();
    tests++; if (bus0.ctrl !== 3'd4)  begin fails++; $display("FAIL mid_grant4 got=%0d want=4", bus0.ctrl); end
    ov = 1'b1; ordy = 1'b1;
    step();
    rst = 1'b1; req = 5'b11111;
    step();
    tests++; if (bus0.en !== 1'b0 || bus0.ctrl !== 3'd0 || bus0.busy !== 1'b0)
      begin fails++; $display("FAIL mid_reset got en=%b ctrl=%0d busy=%b want 0/0/0", bus0.en, bus0.ctrl, bus0.busy); end
    rst = 1'b0;
    step();
    tests++; if (bus0.en !== 1'b1 || bus0.ctrl !== 3'd0)
      begin fails++; $display("FAIL mid_first_grant got en=%b ctrl=%0d want en=1 ctrl=0", bus0.en, bus0.ctrl); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req   = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req = '0;
      ov    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      olast = ($urandom_range(0, 2) == 0);
      step();
      for (int m = 0; m < 2; m++) begin
        logic       en_o, busy_o;
        logic [2:0] ctrl_o;
        en_o   = (m == 0) ? bus0.en   : bus1.en;
        busy_o = (m == 0) ? bus0.busy : bus1.busy;
        ctrl_o = (m == 0) ? bus0.ctrl : bus1.ctrl;
        tests++;
        if (en_o !== 1'(m_locked[m]) || busy_o !== 1'(m_locked[m]) || ctrl_o !== 3'(m_ctrl[m])) begin
          fails++;
          $display("FAIL random[%0d] mode=%0d got en=%b busy=%b ctrl=%0d want en=%0d ctrl=%0d",
                   i, (m == 0) ? 1 : 0, en_o, busy_o, ctrl_o, m_locked[m], m_ctrl[m]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; ov = 1'b0; ordy = 1'b0; olast = 1'b0;
    test_reset();
    test_single_req();
    test_back_to_back();
    test_packet_stall();
    test_hold_last();
    test_beat_rr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
